cnt_seq_checker: RTL and testbench

Receive-side checker for the 4-bit double-rate counter stream produced by the team's dual-edge counter blocks. It samples the stream once per `clk_100M` cycle, checks that each valid sample is the previous sample plus one (modulo 2^W), and acquires and maintains lock with a small state machine. It counts sequence errors while locked and repacks consecutive sample pairs into 2W-bit words for downstream logging.

---
 rtl/cnt_chk_pkg.sv | 16 +
 rtl/cnt_pair_pack.sv | 56 +++++
 rtl/cnt_seq_checker.sv | 116 +++++++++++
 tb/tb_cnt_seq_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared state encodings and default parameters for the counter-stream checker.
package cnt_chk_pkg;

  // 2'd3 is never entered; the FSM treats it as HUNT on the next cycle.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int DEF_W        = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_LOSS_CNT = 2;
  localparam int DEF_ERRW     = 16;

endpackage

// File: rtl/cnt_pair_pack.sv
// Packs consecutive samples into {first, second} words while the checker is locked.
module cnt_pair_pack #(
  parameter int W = 4
) (
  input  logic           clk_100M,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  input  logic [W-1:0]   din,
  output logic [2*W-1:0] pair_data,
  output logic           pair_vld
);

  logic           phase_q, phase_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [2*W-1:0] pair_data_q, pair_data_d;
  logic           pair_vld_q, pair_vld_d;

  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    pair_data_d = pair_data_q;
    pair_vld_d  = 1'b0;
    // clr drops any half pair so a fresh lock always starts on the first word.
    if (clr) begin
      phase_d = 1'b0;
      hold_d  = '0;
    end else if (en) begin
      if (!phase_q) begin
        hold_d = din;
      end else begin
        pair_data_d = {hold_q, din};
        pair_vld_d  = 1'b1;
      end
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      phase_q     <= 1'b0;
      hold_q      <= '0;
      pair_data_q <= '0;
      pair_vld_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      pair_data_q <= pair_data_d;
      pair_vld_q  <= pair_vld_d;
    end
  end

  assign pair_data = pair_data_q;
  assign pair_vld  = pair_vld_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Lock FSM, increment compare and saturating error counter for the double-rate counter stream.
// din is qualified by din_vld only: no backpressure, and cycles with din_vld low change nothing.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERRW     = DEF_ERRW
) (
  input  logic            clk_100M,
  input  logic            rst,
  input  logic [W-1:0]    din,
  input  logic            din_vld,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_cnt,
  output logic [2*W-1:0]  pair_data,
  output logic            pair_vld,
  output logic [1:0]      dbg_state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [GW-1:0]   good_q, good_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic            err_pulse_q, err_pulse_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            match;

  assign match = (din == exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (din_vld) begin
          exp_d   = din + W'(1);
          good_d  = '0;
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (din_vld) begin
          exp_d = din + W'(1);
          if (match) begin
            good_d = good_q + GW'(1);
            if (int'(good_q) + 1 == LOCK_CNT) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (din_vld) begin
          // Expected value free-runs so one corrupted sample costs exactly one error.
          exp_d = exp_q + W'(1);
          if (match) begin
            bad_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRW'(1);
            bad_d = bad_q + BW'(1);
            if (int'(bad_q) + 1 == LOSS_CNT) state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  cnt_pair_pack #(.W(W)) u_pair (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .en        (din_vld && (state_q == ST_LOCKED)),
    .clr       (state_q != ST_LOCKED),
    .din       (din),
    .pair_data (pair_data),
    .pair_vld  (pair_vld)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: vector table for lock/pair/glitch/loss/gap/wrap, then saturation and reset.
module tb_cnt_seq_checker;

  logic clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  logic       rst = 1'b1;
  logic       din_vld = 1'b0;
  logic [3:0] din = 4'h0;

  logic        locked, err_pulse, pair_vld;
  logic [15:0] err_cnt;
  logic [7:0]  pair_data;
  logic [1:0]  dbg_state;

  logic        locked2, err_pulse2, pair_vld2;
  logic [1:0]  err_cnt2;
  logic [7:0]  pair_data2;
  logic [1:0]  dbg_state2;

  cnt_seq_checker dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .pair_data(pair_data),
    .pair_vld (pair_vld),
    .dbg_state(dbg_state)
  );

  cnt_seq_checker #(.ERRW(2), .LOSS_CNT(8)) dut_sat (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .locked   (locked2),
    .err_pulse(err_pulse2),
    .err_cnt  (err_cnt2),
    .pair_data(pair_data2),
    .pair_vld (pair_vld2),
    .dbg_state(dbg_state2)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  din;
    logic [1:0]  st;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic        pv;
    logic [7:0]  pd;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then look at outputs just after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] d);
    @(negedge clk_100M);
    rst     = r;
    din_vld = v;
    din     = d;
    @(posedge clk_100M);
    #1;
  endtask

  task automatic add(input int r, input int v, input int d, input int st, input int lk,
                     input int ep, input int ec, input int pv, input int pd);
    vec_t t;
    t.rst = 1'(r);  t.vld = 1'(v);  t.din = 4'(d);  t.st = 2'(st); t.lk = 1'(lk);
    t.ep  = 1'(ep); t.ec  = 16'(ec); t.pv = 1'(pv); t.pd = 8'(pd);
    tbl.push_back(t);
  endtask

  initial begin
    int n_pulse;
    // rst vld din | state lk ep ec pv pd     (state: 0 HUNT, 1 VERIFY, 2 LOCKED)
    // lock on 3..7, then pairs {8,9} {A,B} {C,D}
    add(0,1,'h3, 1,0,0,0,0,'h00);
    add(0,1,'h4, 1,0,0,0,0,'h00);
    add(0,1,'h5, 1,0,0,0,0,'h00);
    add(0,1,'h6, 1,0,0,0,0,'h00);
    add(0,1,'h7, 2,1,0,0,0,'h00);
    add(0,1,'h8, 2,1,0,0,0,'h00);
    add(0,1,'h9, 2,1,0,0,1,'h89);
    add(0,1,'hA, 2,1,0,0,0,'h89);
    add(0,1,'hB, 2,1,0,0,1,'hAB);
    add(0,1,'hC, 2,1,0,0,0,'hAB);
    add(0,1,'hD, 2,1,0,0,1,'hCD);
    // single glitch: 3 in place of E, then F matches again
    add(0,1,'h3, 2,1,1,1,0,'hCD);
    add(0,1,'hF, 2,1,0,1,1,'h3F);
    add(0,0,'h7, 2,1,0,1,0,'h3F);
    add(0,1,'h0, 2,1,0,1,0,'h3F);
    add(0,1,'h1, 2,1,0,1,1,'h01);
    // two consecutive errors drop lock; the second still pulses and still pairs
    add(0,1,'h5, 2,1,1,2,0,'h01);
    add(0,1,'h5, 0,0,1,3,1,'h55);
    // re-lock needs 1+4 valid samples; gaps carry garbage
    add(0,1,'h1, 1,0,0,3,0,'h55);
    add(0,0,'h9, 1,0,0,3,0,'h55);
    add(0,1,'h2, 1,0,0,3,0,'h55);
    add(0,0,'h2, 1,0,0,3,0,'h55);
    add(0,1,'h3, 1,0,0,3,0,'h55);
    add(0,1,'h4, 1,0,0,3,0,'h55);
    add(0,1,'h5, 2,1,0,3,0,'h55);
    add(0,1,'h6, 2,1,0,3,0,'h55);
    add(0,0,'h0, 2,1,0,3,0,'h55);
    add(0,1,'h7, 2,1,0,3,1,'h67);
    // reset clears the error count, then lock across the F->0 wrap
    add(1,1,'h9, 0,0,0,0,0,'h00);
    add(0,1,'hD, 1,0,0,0,0,'h00);
    add(0,1,'hE, 1,0,0,0,0,'h00);
    add(0,1,'hF, 1,0,0,0,0,'h00);
    add(0,1,'h0, 1,0,0,0,0,'h00);
    add(0,1,'h1, 2,1,0,0,0,'h00);
    add(0,1,'h2, 2,1,0,0,0,'h00);
    add(0,1,'h3, 2,1,0,0,1,'h23);

    repeat (2) @(posedge clk_100M);
    #1;
    check("reset state",     32'(dbg_state), 32'd0);
    check("reset locked",    32'(locked),    32'd0);
    check("reset err_pulse", 32'(err_pulse), 32'd0);
    check("reset err_cnt",   32'(err_cnt),   32'd0);
    check("reset pair_vld",  32'(pair_vld),  32'd0);
    check("reset pair_data", 32'(pair_data), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].din);
      check($sformatf("row%0d state", i),     32'(dbg_state), 32'(tbl[i].st));
      check($sformatf("row%0d locked", i),    32'(locked),    32'(tbl[i].lk));
      check($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(tbl[i].ep));
      check($sformatf("row%0d err_cnt", i),   32'(err_cnt),   32'(tbl[i].ec));
      check($sformatf("row%0d pair_vld", i),  32'(pair_vld),  32'(tbl[i].pv));
      check($sformatf("row%0d pair_data", i), 32'(pair_data), 32'(tbl[i].pd));
    end

    // Saturation on the ERRW=2 / LOSS_CNT=8 instance: lock on 0..4, then five errors.
    step(1'b1, 1'b0, 4'h0);
    for (int v = 0; v <= 4; v++) begin
      step(1'b0, 1'b1, 4'(v));
      check($sformatf("sat lock after %0d", v), 32'(locked2), (v == 4) ? 32'd1 : 32'd0);
    end
    n_pulse = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 4'hA);
      n_pulse += int'(err_pulse2);
      check($sformatf("sat err_pulse %0d", i), 32'(err_pulse2), 32'd1);
      check($sformatf("sat err_cnt %0d", i),   32'(err_cnt2),   (i > 3) ? 32'd3 : 32'(i));
      check($sformatf("sat locked %0d", i),    32'(locked2),    32'd1);
    end
    check("sat pulse total", 32'(n_pulse), 32'd5);

    // Five samples leave a half pair pending; reset must discard it and clear everything.
    step(1'b1, 1'b1, 4'h5);
    check("rst state",     32'(dbg_state2),  32'd0);
    check("rst locked",    32'(locked2),     32'd0);
    check("rst err_pulse", 32'(err_pulse2),  32'd0);
    check("rst err_cnt",   32'(err_cnt2),    32'd0);
    check("rst pair_vld",  32'(pair_vld2),   32'd0);
    check("rst pair_data", 32'(pair_data2),  32'd0);
    step(1'b0, 1'b1, 4'h7);
    check("post rst state",    32'(dbg_state2), 32'd1);
    check("post rst pair_vld", 32'(pair_vld2),  32'd0);
    check("post rst err_cnt",  32'(err_cnt2),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
